fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 124 ++++++++++++
 tb/tb_fetch_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: one outstanding memory request, 2-entry instruction buffer.
// Optional stall counter output perf_stall_cnt is enabled by defining FETCH_SEQ_PERF_EN.
module fetch_seq #(
  parameter logic [63:0] PC_RESET_VAL = 64'h0000000000000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [63:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [63:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail;
  logic        handshake, push, pop;
  logic [31:0] buf_data [2];
  logic [63:0] buf_pc   [2];
  logic        unused_redirect_bits;

  assign unused_redirect_bits = &{1'b0, redirect_pc[1:0]};

  assign imem_req_valid = !reset && (state_q == IDLE) && !halt && !redirect_valid
                          && (count_q < 2'd2);
  assign imem_req_addr  = pc_q;
  assign handshake      = imem_req_valid && imem_req_ready;
  // A response arriving together with a redirect belongs to the old stream.
  assign push           = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop            = inst_valid && inst_ready;
  assign tail           = head_q ^ count_q[0];

  assign inst_valid = (count_q != 2'd0);
  assign inst_data  = buf_data[head_q];
  assign inst_pc    = buf_pc[head_q];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    unique case (state_q)
      IDLE:    if (handshake) state_d = WAIT;
      WAIT:    if (imem_rsp_valid) state_d = IDLE;
               else if (redirect_valid) state_d = DRAIN;
      DRAIN:   if (imem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      pc_d    = {redirect_pc[63:2], 2'b00};
      count_d = 2'd0;
      head_d  = 1'b0;
    end else begin
      if (handshake) pc_d = pc_q + 64'd4;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) head_d = ~head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= {PC_RESET_VAL[63:2], 2'b00};
      req_addr_q <= 64'd0;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      if (handshake) req_addr_q <= pc_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [31:0] data_q;
      logic [63:0] addr_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          data_q <= 32'd0;
          addr_q <= 64'd0;
        end else if (push && (tail == gi[0])) begin
          data_q <= imem_rsp_data;
          addr_q <= req_addr_q;
        end
      end
      assign buf_data[gi] = data_q;
      assign buf_pc[gi]   = addr_q;
    end
  endgenerate

`ifdef FETCH_SEQ_PERF_EN
  logic [63:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 64'd0;
    end else if (imem_req_valid && !imem_req_ready && (stall_cnt_q != {64{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 64'd1;
    end
  end
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: per-cycle vector table plus reset, wrap and stall-counter sequences.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_ready, imem_rsp_valid, redirect_valid, halt, inst_ready;
  logic [31:0] imem_rsp_data;
  logic [63:0] redirect_pc;

  logic        imem_req_valid, inst_valid;
  logic [63:0] imem_req_addr, inst_pc;
  logic [31:0] inst_data;
  logic        w_req_valid, w_inst_valid;
  logic [63:0] w_req_addr, w_inst_pc;
  logic [31:0] w_inst_data;
`ifdef FETCH_SEQ_PERF_EN
  logic [63:0] perf_stall_cnt, w_perf_stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_seq u_dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
`ifdef FETCH_SEQ_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  fetch_seq #(.PC_RESET_VAL(64'hFFFFFFFFFFFFFFF8)) u_dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(w_inst_valid), .inst_data(w_inst_data), .inst_pc(w_inst_pc),
    .inst_ready(inst_ready)
`ifdef FETCH_SEQ_PERF_EN
    , .perf_stall_cnt(w_perf_stall_cnt)
`endif
  );

  typedef struct {
    logic        halt, redir;
    logic [63:0] rpc;
    logic        rdy, rsp;
    logic [31:0] rdata;
    logic        ir;
    logic        erv;
    logic [63:0] eaddr;
    logic        eiv;
    logic [63:0] epc;
    logic [31:0] edata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic h, logic rd, logic [63:0] rpc, logic rdy, logic rsp,
                             logic [31:0] rdata, logic ir, logic erv, logic [63:0] eaddr,
                             logic eiv, logic [63:0] epc, logic [31:0] edata);
    vec_t r;
    r.halt = h; r.redir = rd; r.rpc = rpc; r.rdy = rdy; r.rsp = rsp; r.rdata = rdata;
    r.ir = ir; r.erv = erv; r.eaddr = eaddr; r.eiv = eiv; r.epc = epc; r.edata = edata;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s = %h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    halt = 0; redirect_valid = 0; redirect_pc = 64'd0; imem_req_ready = 0;
    imem_rsp_valid = 0; imem_rsp_data = 32'd0; inst_ready = 0;
  endtask

  initial begin
    //        halt red rpc      rdy rsp data          ir  erv eaddr     eiv epc      edata
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         1, 1, 64'h0,    0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    1, 1, 32'hA0A0_0000, 1, 0, 64'h4,    0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         1, 1, 64'h4,    1, 64'h0,    32'hA0A0_0000));
    vecs.push_back(v(0, 0, 64'h0,    1, 1, 32'hA4A4_0004, 1, 0, 64'h8,    0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         1, 1, 64'h8,    1, 64'h4,    32'hA4A4_0004));
    vecs.push_back(v(0, 0, 64'h0,    1, 1, 32'hA8A8_0008, 1, 0, 64'hC,    0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         0, 1, 64'hC,    1, 64'h8,    32'hA8A8_0008));
    vecs.push_back(v(0, 0, 64'h0,    1, 1, 32'hACAC_000C, 0, 0, 64'h10,   1, 64'h8,    32'hA8A8_0008));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         0, 0, 64'h10,   1, 64'h8,    32'hA8A8_0008));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         0, 0, 64'h10,   1, 64'h8,    32'hA8A8_0008));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         1, 0, 64'h10,   1, 64'h8,    32'hA8A8_0008));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         0, 1, 64'h10,   1, 64'hC,    32'hACAC_000C));
    // redirect to an unaligned target while a request is outstanding
    vecs.push_back(v(0, 1, 64'h1003, 1, 0, 32'h0,         0, 0, 64'h14,   1, 64'hC,    32'hACAC_000C));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         0, 0, 64'h1000, 0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    1, 1, 32'hDEAD_BEEF, 0, 0, 64'h1000, 0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         0, 1, 64'h1000, 0, 64'h0,    32'h0));
    // halt with a request outstanding
    vecs.push_back(v(1, 0, 64'h0,    1, 1, 32'hB0B0_1000, 0, 0, 64'h1004, 0, 64'h0,    32'h0));
    vecs.push_back(v(1, 0, 64'h0,    1, 0, 32'h0,         0, 0, 64'h1004, 1, 64'h1000, 32'hB0B0_1000));
    vecs.push_back(v(1, 0, 64'h0,    1, 0, 32'h0,         1, 0, 64'h1004, 1, 64'h1000, 32'hB0B0_1000));
    vecs.push_back(v(1, 0, 64'h0,    1, 0, 32'h0,         1, 0, 64'h1004, 0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         1, 1, 64'h1004, 0, 64'h0,    32'h0));
    // redirect coincident with response and pop
    vecs.push_back(v(0, 0, 64'h0,    1, 1, 32'hB4B4_1004, 0, 0, 64'h1008, 0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         0, 1, 64'h1008, 1, 64'h1004, 32'hB4B4_1004));
    vecs.push_back(v(0, 1, 64'h2002, 1, 1, 32'hBAD0_BAD0, 1, 0, 64'h100C, 1, 64'h1004, 32'hB4B4_1004));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         1, 1, 64'h2000, 0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    1, 1, 32'hC0C0_2000, 1, 0, 64'h2004, 0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         1, 1, 64'h2004, 1, 64'h2000, 32'hC0C0_2000));
    vecs.push_back(v(0, 0, 64'h0,    1, 1, 32'hC4C4_2004, 0, 0, 64'h2008, 0, 64'h0,    32'h0));
    // redirect in IDLE suppresses the request; stray response in IDLE ignored
    vecs.push_back(v(0, 1, 64'h3000, 1, 0, 32'h0,         0, 0, 64'h2008, 1, 64'h2004, 32'hC4C4_2004));
    vecs.push_back(v(0, 0, 64'h0,    0, 1, 32'hEEEE_EEEE, 0, 1, 64'h3000, 0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    0, 0, 32'h0,         0, 1, 64'h3000, 0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    1, 0, 32'h0,         0, 1, 64'h3000, 0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    1, 1, 32'hF0F0_3000, 0, 0, 64'h3004, 0, 64'h0,    32'h0));
    vecs.push_back(v(0, 0, 64'h0,    0, 0, 32'h0,         1, 1, 64'h3004, 1, 64'h3000, 32'hF0F0_3000));

    idle_inputs();
    reset = 1;
    tick();
    tick();
    chk("reset req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("reset inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("reset inst_pc", inst_pc, 64'd0);
    chk("reset inst_data", {32'd0, inst_data}, 64'd0);
    reset = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      halt = vecs[i].halt; redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
      imem_req_ready = vecs[i].rdy; imem_rsp_valid = vecs[i].rsp;
      imem_rsp_data = vecs[i].rdata; inst_ready = vecs[i].ir;
      #1;
      chk($sformatf("row%0d req_valid", i), {63'd0, imem_req_valid}, {63'd0, vecs[i].erv});
      chk($sformatf("row%0d req_addr", i), imem_req_addr, vecs[i].eaddr);
      chk($sformatf("row%0d inst_valid", i), {63'd0, inst_valid}, {63'd0, vecs[i].eiv});
      if (vecs[i].eiv) begin
        chk($sformatf("row%0d inst_pc", i), inst_pc, vecs[i].epc);
        chk($sformatf("row%0d inst_data", i), {32'd0, inst_data}, {32'd0, vecs[i].edata});
      end
      tick();
    end
    idle_inputs();

    // reset while a request is outstanding; the late response lands in IDLE
    imem_req_ready = 1;
    #1;
    chk("midrst req_valid before", {63'd0, imem_req_valid}, 64'd1);
    tick();
    reset = 1;
    #1;
    chk("midrst req_valid in reset", {63'd0, imem_req_valid}, 64'd0);
    tick();
    reset = 0; imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h9999_9999;
    #1;
    chk("midrst req_addr", imem_req_addr, 64'd0);
    chk("midrst req_valid", {63'd0, imem_req_valid}, 64'd1);
    tick();
    imem_rsp_valid = 0;
    #1;
    chk("midrst rsp ignored", {63'd0, inst_valid}, 64'd0);

    // wrap-around of the fetch address
    reset = 1;
    tick();
    reset = 0; imem_req_ready = 1; inst_ready = 1;
    #1;
    chk("wrap addr0", w_req_addr, 64'hFFFFFFFFFFFFFFF8);
    tick();
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_00F8;
    tick();
    imem_rsp_valid = 0;
    #1;
    chk("wrap addr1", w_req_addr, 64'hFFFFFFFFFFFFFFFC);
    chk("wrap inst_pc0", w_inst_pc, 64'hFFFFFFFFFFFFFFF8);
    tick();
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_00FC;
    tick();
    imem_rsp_valid = 0;
    #1;
    chk("wrap addr2", w_req_addr, 64'h0);
    chk("wrap inst_pc1", w_inst_pc, 64'hFFFFFFFFFFFFFFFC);
    chk("wrap req_valid", {63'd0, w_req_valid}, 64'd1);
    idle_inputs();

`ifdef FETCH_SEQ_PERF_EN
    reset = 1;
    tick();
    reset = 0; imem_req_ready = 0;
    #1;
    chk("perf after reset", perf_stall_cnt, 64'd0);
    for (int c = 0; c < 5; c++) tick();
    imem_req_ready = 1;
    #1;
    chk("perf 5 stalls", perf_stall_cnt, 64'd5);
    idle_inputs();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
